// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit. Issues accesses on a valid/ready
//               data-memory port, builds byte-lane enables and replicated
//               store data, and returns aligned sign/zero-extended load data
//               to the MEM/WB register. It stalls the front of the pipeline
//               while an access is outstanding. Misaligned accesses and bus
//               time-outs are reported to the trap logic.
// Ports       :
//   clk, rst               clock, synchronous active-high reset
//   Int_flush              trap/interrupt flush of the M-stage instruction
//   MemReadM / MemWriteM   M-stage load / store
//   funct3M                access size and signedness
//   ALUResultM             effective byte address
//   WriteDataM             store data (rs2)
//   HoldM                  external M-stage stall from the hazard unit
//   dmem_rdata/dmem_ready  memory read data / request accepted+completed
//   dmem_req/we/addr/be/wdata  memory request channel
//   ReadData               extended load result
//   StallM                 hold IF..M this cycle
//   MisalignedM            misaligned access pulse
//   AccessFaultM           bus time-out pulse
//   FaultAddrM             byte address of the faulting access
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Int_flush,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        HoldM,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignedM,
  output logic        AccessFaultM,
  output logic [31:0] FaultAddrM
);

  localparam int            CW         = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [31:0]   r_rdata_q, w_rdata_q_nx;

  // Request attributes latched at issue. Once a request is on the bus it is
  // driven from these so that a flush (which may turn the M-stage inputs into
  // a bubble) cannot change an access that memory has not yet completed.
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [2:0]    r_f3;

  logic          w_op;
  logic          w_mis;
  logic          w_issue;
  logic [3:0]    w_be_new;
  logic [31:0]   w_wdata_new;
  logic [31:0]   w_idle_rdata;
  logic [31:0]   w_wait_rdata;

  // Extract the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'h0, b};
      3'b101:  load_extend = {16'h0, h};
      default: load_extend = rd;
    endcase
  endfunction

  // No access is started while reset is asserted, so a reset in the middle
  // of an access leaves the bus quiet on the following cycle.
  assign w_op  = (MemReadM | MemWriteM) & ~Int_flush & ~rst;
  assign w_mis = ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)) |
                 ((funct3M[1:0] == 2'b01) & ALUResultM[0]);
  assign w_issue = w_op & ~w_mis;

  always_comb begin
    w_be_new    = 4'hF;
    w_wdata_new = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        w_be_new    = 4'b0001 << ALUResultM[1:0];
        w_wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_be_new    = 4'b0011 << ALUResultM[1:0];
        w_wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be_new    = 4'hF;
        w_wdata_new = WriteDataM;
      end
    endcase
  end

  // Stores return zero; a request that is both read and write is a store.
  assign w_idle_rdata = MemWriteM ? 32'h0 :
                        load_extend(dmem_rdata, funct3M, ALUResultM[1:0]);
  assign w_wait_rdata = r_we ? 32'h0 :
                        load_extend(dmem_rdata, r_f3, r_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rdata_q <= 32'h0;
      r_addr    <= 32'h0;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rdata_q <= w_rdata_q_nx;
      if ((r_state == S_IDLE) && w_issue) begin
        r_addr  <= ALUResultM;
        r_be    <= w_be_new;
        r_wdata <= w_wdata_new;
        r_we    <= MemWriteM;
        r_f3    <= funct3M;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_rdata_q_nx = r_rdata_q;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 32'h0;
    dmem_be      = 4'h0;
    dmem_wdata   = 32'h0;
    ReadData     = 32'h0;
    StallM       = 1'b0;
    MisalignedM  = 1'b0;
    AccessFaultM = 1'b0;
    FaultAddrM   = 32'h0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_op && w_mis) begin
          MisalignedM = 1'b1;
          FaultAddrM  = ALUResultM;
        end else if (w_issue) begin
          dmem_req   = 1'b1;
          dmem_we    = MemWriteM;
          dmem_addr  = {ALUResultM[31:2], 2'b00};
          dmem_be    = w_be_new;
          dmem_wdata = w_wdata_new;
          StallM     = ~dmem_ready;
          if (dmem_ready) begin
            ReadData = w_idle_rdata;
            if (HoldM) begin
              w_rdata_q_nx = w_idle_rdata;
              w_state_nx   = S_HELD;
            end
          end else begin
            w_cnt_nx   = CW'(1);
            w_state_nx = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = {r_addr[31:2], 2'b00};
        dmem_be    = r_be;
        dmem_wdata = r_wdata;
        if (Int_flush) begin
          // The instruction is being killed: its result is dropped, but the
          // bus request must run to completion (or silent time-out).
          if (dmem_ready) begin
            w_state_nx = S_IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = 32'h0;
            dmem_be    = 4'h0;
            dmem_wdata = 32'h0;
            w_state_nx = S_IDLE;
          end else begin
            StallM     = 1'b1;
            w_cnt_nx   = r_cnt + CW'(1);
            w_state_nx = S_DRAIN;
          end
        end else if (dmem_ready) begin
          ReadData = w_wait_rdata;
          if (HoldM) begin
            w_rdata_q_nx = w_wait_rdata;
            w_state_nx   = S_HELD;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else if (r_cnt == C_CNT_LAST) begin
          dmem_req     = 1'b0;
          dmem_we      = 1'b0;
          dmem_addr    = 32'h0;
          dmem_be      = 4'h0;
          dmem_wdata   = 32'h0;
          AccessFaultM = 1'b1;
          FaultAddrM   = r_addr;
          w_state_nx   = S_IDLE;
        end else begin
          StallM   = 1'b1;
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      S_HELD: begin
        // The access is finished; the result is replayed while the stage is
        // held and the bus stays idle so a store is never performed twice.
        ReadData = r_rdata_q;
        if (Int_flush || !HoldM) begin
          w_rdata_q_nx = 32'h0;
          w_state_nx   = S_IDLE;
        end
      end

      S_DRAIN: begin
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = {r_addr[31:2], 2'b00};
        dmem_be    = r_be;
        dmem_wdata = r_wdata;
        StallM     = ~dmem_ready;
        if (dmem_ready) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          dmem_req   = 1'b0;
          dmem_we    = 1'b0;
          dmem_addr  = 32'h0;
          dmem_be    = 4'h0;
          dmem_wdata = 32'h0;
          StallM     = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Directed self-checking bench for mem_stage_lsu. Inputs are
//               driven 1 time unit after the rising edge, outputs are
//               sampled 3 time units later, mid-cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        Int_flush;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        HoldM;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] ReadData;
  logic        StallM;
  logic        MisalignedM;
  logic        AccessFaultM;
  logic [31:0] FaultAddrM;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mem_stage_lsu #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .Int_flush    (Int_flush),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .funct3M      (funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .HoldM        (HoldM),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .ReadData     (ReadData),
    .StallM       (StallM),
    .MisalignedM  (MisalignedM),
    .AccessFaultM (AccessFaultM),
    .FaultAddrM   (FaultAddrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    Int_flush  = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    HoldM      = 1'b0;
    dmem_rdata = 32'h0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    settle();
    // Reset state: everything quiet.
    chk("rst_req",   dmem_req,     1'b0);
    chk("rst_stall", StallM,       1'b0);
    chk("rst_rdata", ReadData,     32'h0);
    chk("rst_fault", AccessFaultM, 1'b0);
    chk("rst_faddr", FaultAddrM,   32'h0);

    // 1. LB 0x1003, zero-wait, byte 0x80 sign-extended.
    tick(); rst = 1'b0;
    MemReadM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h0000_1003;
    dmem_rdata = 32'h80FF_0000; dmem_ready = 1'b1;
    settle();
    chk("lb_req",   dmem_req,  1'b1);
    chk("lb_we",    dmem_we,   1'b0);
    chk("lb_addr",  dmem_addr, 32'h0000_1000);
    chk("lb_stall", StallM,    1'b0);
    chk("lb_rdata", ReadData,  32'hFFFF_FF80);
    tick(); idle_inputs(); settle();
    chk("lb_done_req",   dmem_req, 1'b0);
    chk("lb_done_rdata", ReadData, 32'h0);

    // 2. SH 0x2002, ready on the 4th cycle.
    tick();
    MemWriteM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h0000_2002;
    WriteDataM = 32'h1234_ABCD; dmem_ready = 1'b0;
    settle();
    chk("sh_req",   dmem_req,   1'b1);
    chk("sh_we",    dmem_we,    1'b1);
    chk("sh_be",    dmem_be,    4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_stall0", StallM,    1'b1);
    tick(); settle();
    chk("sh_stall1", StallM,  1'b1);
    chk("sh_be1",    dmem_be, 4'b1100);
    tick(); settle();
    chk("sh_stall2", StallM, 1'b1);
    tick(); dmem_ready = 1'b1; settle();
    chk("sh_ready_req",   dmem_req, 1'b1);
    chk("sh_ready_stall", StallM,   1'b0);
    chk("sh_ready_rdata", ReadData, 32'h0);
    tick(); idle_inputs(); settle();
    chk("sh_done_req", dmem_req, 1'b0);

    // 3. Misaligned LW, then aligned LHU.
    tick();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_3001;
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("mis_req",   dmem_req,    1'b0);
    chk("mis_flag",  MisalignedM, 1'b1);
    chk("mis_addr",  FaultAddrM,  32'h0000_3001);
    chk("mis_stall", StallM,      1'b0);
    chk("mis_rdata", ReadData,    32'h0);
    tick();
    funct3M = 3'b101; ALUResultM = 32'h0000_3002; dmem_rdata = 32'h8765_0000;
    settle();
    chk("lhu_mis",   MisalignedM, 1'b0);
    chk("lhu_rdata", ReadData,    32'h0000_8765);
    // LBU lane 2, zero-extended.
    tick();
    funct3M = 3'b100; ALUResultM = 32'h0000_0002; dmem_rdata = 32'h00AB_0000;
    settle();
    chk("lbu_rdata", ReadData, 32'h0000_00AB);
    // Flush in IDLE suppresses both the request and the misaligned pulse.
    tick();
    funct3M = 3'b010; ALUResultM = 32'h0000_0003; Int_flush = 1'b1;
    settle();
    chk("flush_idle_req", dmem_req,    1'b0);
    chk("flush_idle_mis", MisalignedM, 1'b0);
    tick(); idle_inputs(); settle();

    // 4. SW never ready: request in cycles 0..14, fault pulse in cycle 15.
    tick();
    MemWriteM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_4000;
    WriteDataM = 32'hDEAD_BEEF; dmem_ready = 1'b0;
    settle();
    chk("sw_be",    dmem_be,    4'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_req0",  dmem_req,   1'b1);
    for (int c = 1; c < 15; c++) begin
      tick(); settle();
      chk($sformatf("sw_req_c%0d", c),   dmem_req,     1'b1);
      chk($sformatf("sw_fault_c%0d", c), AccessFaultM, 1'b0);
    end
    tick(); settle();
    chk("sw_to_fault", AccessFaultM, 1'b1);
    chk("sw_to_req",   dmem_req,     1'b0);
    chk("sw_to_addr",  FaultAddrM,   32'h0000_4000);
    chk("sw_to_stall", StallM,       1'b0);
    tick(); idle_inputs(); settle();
    chk("sw_after_fault", AccessFaultM, 1'b0);
    chk("sw_after_req",   dmem_req,     1'b0);

    // 5. SB zero-wait with HoldM: one handshake, then HELD with bus idle.
    tick();
    MemWriteM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h0000_5001;
    WriteDataM = 32'h0000_00A5; dmem_ready = 1'b1; HoldM = 1'b1;
    settle();
    chk("sb_req",   dmem_req,   1'b1);
    chk("sb_be",    dmem_be,    4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_stall", StallM,     1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); settle();
      chk($sformatf("sb_held_req_c%0d", c),   dmem_req, 1'b0);
      chk($sformatf("sb_held_stall_c%0d", c), StallM,   1'b0);
    end
    tick(); HoldM = 1'b0; settle();
    chk("sb_release_req", dmem_req, 1'b0);
    tick(); idle_inputs(); settle();
    chk("sb_idle_req", dmem_req, 1'b0);

    // 5b. LH via WAIT with HoldM: held value replayed from the capture.
    tick();
    MemReadM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h0000_6002;
    dmem_rdata = 32'h8001_1234; dmem_ready = 1'b0; HoldM = 1'b1;
    settle();
    chk("lh_stall0", StallM, 1'b1);
    tick(); dmem_ready = 1'b1; settle();
    chk("lh_rdata", ReadData, 32'hFFFF_8001);
    chk("lh_stall", StallM,   1'b0);
    tick(); dmem_ready = 1'b0; dmem_rdata = 32'h0; settle();
    chk("lh_held_rdata", ReadData, 32'hFFFF_8001);
    chk("lh_held_req",   dmem_req, 1'b0);
    tick(); HoldM = 1'b0; settle();
    chk("lh_rel_rdata", ReadData, 32'hFFFF_8001);
    tick(); idle_inputs(); settle();
    chk("lh_idle_rdata", ReadData, 32'h0);

    // 6. LW in WAIT flushed: drained to completion, result discarded.
    tick();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_7000;
    dmem_ready = 1'b0;
    settle();
    chk("dr_req0", dmem_req, 1'b1);
    tick(); settle();
    tick(); Int_flush = 1'b1; settle();
    chk("dr_flush_req",   dmem_req, 1'b1);
    chk("dr_flush_stall", StallM,   1'b1);
    tick(); Int_flush = 1'b0; MemReadM = 1'b0; ALUResultM = 32'h0000_9999; settle();
    chk("dr_req",   dmem_req,  1'b1);
    chk("dr_addr",  dmem_addr, 32'h0000_7000);
    chk("dr_stall", StallM,    1'b1);
    tick(); settle();
    chk("dr_stall2", StallM, 1'b1);
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678; settle();
    chk("dr_ready_req",   dmem_req,     1'b1);
    chk("dr_ready_rdata", ReadData,     32'h0);
    chk("dr_ready_fault", AccessFaultM, 1'b0);
    chk("dr_ready_mis",   MisalignedM,  1'b0);
    tick(); idle_inputs(); settle();
    chk("dr_done_req", dmem_req, 1'b0);

    // 7. Reset in the middle of WAIT drops the request the next cycle.
    tick();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_8000;
    dmem_ready = 1'b0;
    settle();
    tick(); rst = 1'b1; settle();
    chk("rw_req_before", dmem_req, 1'b1);
    tick(); settle();
    chk("rw_req_after",   dmem_req, 1'b0);
    chk("rw_stall_after", StallM,   1'b0);
    tick(); rst = 1'b0; idle_inputs(); settle();
    chk("rw_idle_req", dmem_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
